// File: rtl/gb_timer_pkg.sv
// Shared constants for the multi-channel timer: register offsets, CTRL bit layout, tap defaults.
// Latency: n/a (constants only).
// Backpressure: n/a.
package gb_timer_pkg;

  // Slot 0 (global) register offsets
  localparam logic [1:0] REG_DIV    = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_IRQEN  = 2'd2;

  // Slot 1..CHANNELS register offsets
  localparam logic [1:0] REG_COUNT  = 2'd0;
  localparam logic [1:0] REG_RELOAD = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  // CTRL bit positions
  localparam int CTRL_SEL_LSB = 0;
  localparam int CTRL_EN      = 2;
  localparam int CTRL_ONESHOT = 3;
  localparam int CTRL_CHAIN   = 4;
  localparam int CTRL_W       = 5;

  // Default divider tap table, indexed by CTRL.sel
  localparam int DEF_TAP0 = 9;
  localparam int DEF_TAP1 = 3;
  localparam int DEF_TAP2 = 5;
  localparam int DEF_TAP3 = 7;

endpackage

// File: rtl/gb_timer_channel.sv
// One reloadable timer channel: tap edge detect or chain tick, wrap, delayed flag and reload.
// Latency: ovf combinational in the wrap ce; flag_set IRQ_DELAY ce later; reload on the ce after.
// Backpressure: none; write strobes are qualified by ce and always accepted.
module gb_timer_channel
  import gb_timer_pkg::*;
#(
  parameter int IDX       = 1,
  parameter int CNT_W     = 8,
  parameter int DIV_W     = 16,
  parameter int IRQ_DELAY = 4,
  parameter int TAP0      = DEF_TAP0,
  parameter int TAP1      = DEF_TAP1,
  parameter int TAP2      = DEF_TAP2,
  parameter int TAP3      = DEF_TAP3
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             ce,
  input  logic [DIV_W-1:0] div,
  input  logic             chain_in,
  input  logic             wr_count,
  input  logic             wr_reload,
  input  logic             wr_ctrl,
  input  logic [CNT_W-1:0] wr_dat,
  input  logic [1:0]       rd_reg,
  output logic [CNT_W-1:0] rd_dat,
  output logic             ovf,
  output logic             flag_set
);

  // Pipe stage encoding: 0 idle, 1..IRQ_DELAY counting, IRQ_DELAY+1 reload pending
  localparam int DLY_W = 4;
  localparam logic [DLY_W-1:0] DLY_FLAG   = DLY_W'(IRQ_DELAY);
  localparam logic [DLY_W-1:0] DLY_RELOAD = DLY_W'(IRQ_DELAY + 1);

  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  reload_q, reload_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              t_prev_q, t_prev_d;
  logic [DLY_W-1:0]  dly_q, dly_d;

  logic tap_bit, t_now, chained, tick, in_reload, count_wr_takes;
  logic div_unused;

  // Only the tap bits of the divider matter here
  assign div_unused = ^div;

  // Tick source: falling edge of the enabled tap, or the previous channel's wrap when chained
  always_comb begin
    case (ctrl_q[CTRL_SEL_LSB +: 2])
      2'd0:    tap_bit = div[TAP0];
      2'd1:    tap_bit = div[TAP1];
      2'd2:    tap_bit = div[TAP2];
      default: tap_bit = div[TAP3];
    endcase
    t_now          = ctrl_q[CTRL_EN] & tap_bit;
    chained        = ctrl_q[CTRL_CHAIN] && (IDX > 1);
    tick           = ce & (chained ? (ctrl_q[CTRL_EN] & chain_in) : (t_prev_q & ~t_now));
    in_reload      = (dly_q == DLY_RELOAD);
    // A COUNT write lands when idle or in the early delay stages (which it cancels)
    count_wr_takes = wr_count & (dly_q < DLY_FLAG);
    ovf            = tick & (&count_q) & ~count_wr_takes & ~in_reload;
    flag_set       = ce & (dly_q == DLY_FLAG);
  end

  // Next-state: write priority, counting, delay pipe, reload and one-shot disable
  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    ctrl_d   = ctrl_q;
    t_prev_d = t_prev_q;
    dly_d    = dly_q;
    if (ce) begin
      t_prev_d = t_now;
      if (wr_reload) reload_d = wr_dat;
      if (wr_ctrl)   ctrl_d   = wr_dat[CTRL_W-1:0];
      if (dly_q == DLY_FLAG) begin
        dly_d = DLY_RELOAD;
      end else if (dly_q != '0 && dly_q < DLY_FLAG) begin
        dly_d = dly_q + 1'b1;
      end
      if (in_reload) begin
        // A RELOAD write in this ce feeds COUNT straight from the bus
        count_d = wr_reload ? wr_dat : reload_q;
        dly_d   = '0;
        if (ctrl_q[CTRL_ONESHOT] && !wr_ctrl) ctrl_d[CTRL_EN] = 1'b0;
      end else if (count_wr_takes) begin
        count_d = wr_dat;
        dly_d   = '0;
      end else if (tick) begin
        count_d = count_q + 1'b1;
        if (ovf) dly_d = DLY_W'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      count_q  <= '0;
      reload_q <= '0;
      ctrl_q   <= '0;
      t_prev_q <= 1'b0;
      dly_q    <= '0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      ctrl_q   <= ctrl_d;
      t_prev_q <= t_prev_d;
      dly_q    <= dly_d;
    end
  end

  // Read data; unused CTRL bits and reg3 read as ones
  always_comb begin
    case (rd_reg)
      REG_COUNT:  rd_dat = count_q;
      REG_RELOAD: rd_dat = reload_q;
      REG_CTRL:   rd_dat = {{(CNT_W-CTRL_W){1'b1}}, ctrl_q};
      default:    rd_dat = '1;
    endcase
  end

endmodule

// File: rtl/gb_timer_multi.sv
// Multi-channel timer: shared divider, CHANNELS counters, STATUS/IRQ_EN and the CPU register file.
// Latency: reads combinational; writes land on the next ce edge, DIV clear and STATUS W1C at once.
// Backpressure: none; every CPU access completes in one cycle.
module gb_timer_multi
  import gb_timer_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int CNT_W     = 8,
  parameter int DIV_W     = 16,
  parameter int IRQ_DELAY = 4,
  parameter int TAP0      = DEF_TAP0,
  parameter int TAP1      = DEF_TAP1,
  parameter int TAP2      = DEF_TAP2,
  parameter int TAP3      = DEF_TAP3,
  parameter int AW        = $clog2(CHANNELS + 1) + 2
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                ce,
  input  logic                cpu_sel,
  input  logic [AW-1:0]       cpu_addr,
  input  logic                cpu_wr,
  input  logic [CNT_W-1:0]    cpu_di,
  output logic [CNT_W-1:0]    cpu_do,
  output logic                irq,
  output logic [CHANNELS-1:0] ovf
);

  localparam int SW = AW - 2;

  logic [DIV_W-1:0]    div_q, div_d;
  logic [CHANNELS-1:0] status_q, status_d;
  logic [CHANNELS-1:0] irqen_q, irqen_d;
  logic [CHANNELS-1:0] flag_vec;
  logic [CNT_W-1:0]    ch_rd [CHANNELS];

  logic [SW-1:0] slot;
  logic [1:0]    rg;
  logic          wr_en, wr_div, wr_status, wr_irqen;

  assign slot      = cpu_addr[AW-1:2];
  assign rg        = cpu_addr[1:0];
  assign wr_en     = cpu_sel & cpu_wr;
  assign wr_div    = wr_en && slot == '0 && rg == REG_DIV;
  assign wr_status = wr_en && slot == '0 && rg == REG_STATUS;
  assign wr_irqen  = wr_en && slot == '0 && rg == REG_IRQEN;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic ch_ovf, chain_in;
    if (g == 0) begin : g_first
      assign chain_in = 1'b0;
    end else begin : g_rest
      assign chain_in = g_ch[g-1].ch_ovf;
    end
    assign ovf[g] = ch_ovf;

    gb_timer_channel #(
      .IDX(g + 1), .CNT_W(CNT_W), .DIV_W(DIV_W), .IRQ_DELAY(IRQ_DELAY),
      .TAP0(TAP0), .TAP1(TAP1), .TAP2(TAP2), .TAP3(TAP3)
    ) u_ch (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .ce       (ce),
      .div      (div_q),
      .chain_in (chain_in),
      .wr_count (wr_en && slot == SW'(g + 1) && rg == REG_COUNT),
      .wr_reload(wr_en && slot == SW'(g + 1) && rg == REG_RELOAD),
      .wr_ctrl  (wr_en && slot == SW'(g + 1) && rg == REG_CTRL),
      .wr_dat   (cpu_di),
      .rd_reg   (rg),
      .rd_dat   (ch_rd[g]),
      .ovf      (ch_ovf),
      .flag_set (flag_vec[g])
    );
  end

  // Divider, STATUS (set beats W1C) and IRQ_EN next-state
  always_comb begin
    div_d = div_q;
    if (ce)     div_d = div_q + 1'b1;
    if (wr_div) div_d = '0;
    status_d = (status_q & ~(wr_status ? cpu_di[CHANNELS-1:0] : '0)) | flag_vec;
    irqen_d  = irqen_q;
    if (ce && wr_irqen) irqen_d = cpu_di[CHANNELS-1:0];
  end

  // Global registers
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      div_q    <= '0;
      status_q <= '0;
      irqen_q  <= '0;
    end else begin
      div_q    <= div_d;
      status_q <= status_d;
      irqen_q  <= irqen_d;
    end
  end

  assign irq = |(status_q & irqen_q);

  // Read mux; unmapped slots and registers read all ones
  always_comb begin
    cpu_do = '1;
    if (slot == '0) begin
      case (rg)
        REG_DIV:    cpu_do = div_q[DIV_W-1 -: CNT_W];
        REG_STATUS: cpu_do = CNT_W'(status_q);
        REG_IRQEN:  cpu_do = CNT_W'(irqen_q);
        default:    cpu_do = '1;
      endcase
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (slot == SW'(k + 1)) cpu_do = ch_rd[k];
      end
    end
  end

endmodule

// File: tb/tb_gb_timer_multi.sv
// Directed bench for gb_timer_multi: stimulus pushes expected values, a monitor pops and compares.
// Latency: checks sample at the falling edge inside the stimulus cycle.
// Backpressure: n/a.
module tb_gb_timer_multi;

  localparam int K_RD  = 0;
  localparam int K_IRQ = 1;
  localparam int K_OVF = 2;

  localparam logic [3:0] A_DIV = 4'h0, A_STAT = 4'h1, A_IEN = 4'h2, A_G3 = 4'h3;
  localparam logic [3:0] A_C1 = 4'h4, A_R1 = 4'h5, A_K1 = 4'h6, A_X1 = 4'h7;
  localparam logic [3:0] A_C2 = 4'h8, A_K2 = 4'hA, A_UNM = 4'hC;

  typedef struct {
    string      nm;
    int         kind;
    logic [7:0] val;
  } exp_t;

  logic       clk_sys = 1'b0;
  logic       reset, ce, cpu_sel, cpu_wr, chk_vld;
  logic [3:0] cpu_addr;
  logic [7:0] cpu_di;
  logic [7:0] cpu_do;
  logic       irq;
  logic [1:0] ovf;

  exp_t exp_q[$];
  exp_t e;
  logic [7:0] act;
  int n_pass = 0;
  int n_total = 0;

  gb_timer_multi dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .ce      (ce),
    .cpu_sel (cpu_sel),
    .cpu_addr(cpu_addr),
    .cpu_wr  (cpu_wr),
    .cpu_di  (cpu_di),
    .cpu_do  (cpu_do),
    .irq     (irq),
    .ovf     (ovf)
  );

  always #5 clk_sys = ~clk_sys;

  // Monitor: pops one expectation per strobed cycle and compares at the falling edge
  always @(negedge clk_sys) begin
    if (chk_vld) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL scoreboard_empty: monitor strobed with no expected value queued");
      end else begin
        e = exp_q.pop_front();
        if (e.kind == K_RD)       act = cpu_do;
        else if (e.kind == K_IRQ) act = {7'b0, irq};
        else                      act = {6'b0, ovf};
        n_total++;
        if (act === e.val) n_pass++;
        else $display("FAIL %s: got 0x%02h expected 0x%02h", e.nm, act, e.val);
      end
    end
  end

  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      ce = 1'b1;
      cyc();
      ce = 1'b0;
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    ce = 1'b1; cpu_sel = 1'b1; cpu_wr = 1'b1; cpu_addr = a; cpu_di = d;
    cyc();
    ce = 1'b0; cpu_sel = 1'b0; cpu_wr = 1'b0;
  endtask

  task automatic expect_now(input string nm, input int kind, input logic [7:0] v, input logic ce_v);
    exp_t x;
    x.nm = nm; x.kind = kind; x.val = v;
    exp_q.push_back(x);
    ce = ce_v; chk_vld = 1'b1;
    cyc();
    ce = 1'b0; chk_vld = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [3:0] a, input logic [7:0] v);
    cpu_addr = a;
    expect_now(nm, K_RD, v, 1'b0);
  endtask

  task automatic chk_irq(input string nm, input logic v);
    expect_now(nm, K_IRQ, {7'b0, v}, 1'b0);
  endtask

  task automatic step_ovf(input string nm, input logic [1:0] v);
    expect_now(nm, K_OVF, {6'b0, v}, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1; ce = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  // Common lead-in: CH1 RELOAD=0x80, COUNT=0xFE, en|sel=1 -> wraps in ce #32
  task automatic setup_wrap();
    do_reset();
    wr(A_R1, 8'h80);
    wr(A_C1, 8'hFE);
    wr(A_K1, 8'h05);
    step(28);
    step_ovf("pre_wrap_ovf", 2'b00);
    step_ovf("wrap_ovf", 2'b01);
  endtask

  initial begin
    reset = 1'b1; ce = 1'b0; cpu_sel = 1'b0; cpu_wr = 1'b0; chk_vld = 1'b0;
    cpu_addr = '0; cpu_di = '0;
    do_reset();

    // Reset state
    rd("rst_div", A_DIV, 8'h00);
    rd("rst_status", A_STAT, 8'h00);
    rd("rst_irqen", A_IEN, 8'h00);
    rd("rst_count1", A_C1, 8'h00);
    rd("rst_reload1", A_R1, 8'h00);
    rd("rst_ctrl1", A_K1, 8'hE0);
    rd("rst_ctrl2", A_K2, 8'hE0);
    rd("rst_g_reg3", A_G3, 8'hFF);
    rd("rst_c1_reg3", A_X1, 8'hFF);
    rd("rst_unmapped", A_UNM, 8'hFF);
    chk_irq("rst_irq", 1'b0);
    step_ovf("rst_ovf", 2'b00);

    // Basic wrap, delayed flag, reload, IRQ mask and W1C
    setup_wrap();
    rd("wrap_count", A_C1, 8'h00);
    step(3);
    rd("status_early", A_STAT, 8'h00);
    step(1);
    rd("status_set", A_STAT, 8'h01);
    chk_irq("irq_masked", 1'b0);
    rd("count_before_reload", A_C1, 8'h00);
    step(1);
    rd("count_reloaded", A_C1, 8'h80);
    wr(A_IEN, 8'h01);
    chk_irq("irq_enabled", 1'b1);
    wr(A_STAT, 8'h01);
    chk_irq("irq_after_w1c", 1'b0);
    rd("status_after_w1c", A_STAT, 8'h00);

    // COUNT write two ce after wrap cancels flag and reload
    setup_wrap();
    step(1);
    wr(A_C1, 8'h33);
    step(6);
    rd("cancel_status", A_STAT, 8'h00);
    rd("cancel_count", A_C1, 8'h33);

    // RELOAD write in the reload ce goes straight to COUNT
    setup_wrap();
    step(4);
    wr(A_R1, 8'h55);
    rd("rl_wr_count", A_C1, 8'h55);
    rd("rl_wr_reload", A_R1, 8'h55);
    rd("rl_wr_status", A_STAT, 8'h01);

    // COUNT write in the flag-set ce is ignored; reload still happens
    setup_wrap();
    step(3);
    wr(A_C1, 8'h11);
    rd("flagce_wr_ignored", A_C1, 8'h00);
    rd("flagce_status", A_STAT, 8'h01);
    step(1);
    rd("flagce_reload", A_C1, 8'h80);

    // Chaining: CH2 counts CH1 wraps, its ovf coincides with CH1's
    do_reset();
    wr(A_R1, 8'hFF);
    wr(A_C1, 8'hFF);
    wr(A_K2, 8'h14);
    wr(A_K1, 8'h05);
    step(12);
    step_ovf("chain_ovf1", 2'b01);
    rd("chain_cnt1", A_C2, 8'h01);
    step(15);
    step_ovf("chain_ovf2", 2'b01);
    rd("chain_cnt2", A_C2, 8'h02);
    wr(A_C2, 8'hFF);
    step(14);
    step_ovf("chain_ovf_both", 2'b11);
    rd("chain_status_a", A_STAT, 8'h01);
    step(4);
    rd("chain_status_b", A_STAT, 8'h03);

    // One-shot: single wrap, reload, en drops, no further counting
    do_reset();
    wr(A_R1, 8'h40);
    wr(A_C1, 8'hFF);
    wr(A_K1, 8'h0D);
    step(13);
    step_ovf("os_ovf", 2'b01);
    step(5);
    rd("os_count", A_C1, 8'h40);
    rd("os_ctrl", A_K1, 8'hE9);
    rd("os_status", A_STAT, 8'h01);
    wr(A_STAT, 8'h01);
    step(250);
    rd("os_count_held", A_C1, 8'h40);
    rd("os_status_quiet", A_STAT, 8'h00);
    rd("os_div_hi", A_DIV, 8'h01);

    // DIV write while tap is high: exactly one spurious tick, divider phase restarts
    do_reset();
    wr(A_C1, 8'h10);
    wr(A_K1, 8'h05);
    step(8);
    wr(A_DIV, 8'h5A);
    rd("div_wr_count", A_C1, 8'h10);
    step(1);
    rd("div_spurious", A_C1, 8'h11);
    step(7);
    rd("div_no_more", A_C1, 8'h11);
    step(9);
    rd("div_next_edge", A_C1, 8'h12);

    // Reset in the middle of the delay pipe drops the pending IRQ
    do_reset();
    wr(A_R1, 8'h80);
    wr(A_C1, 8'hFE);
    wr(A_K1, 8'h05);
    wr(A_IEN, 8'h01);
    step(28);
    step_ovf("rstmid_wrap", 2'b01);
    step(2);
    do_reset();
    step(10);
    chk_irq("rstmid_irq", 1'b0);
    rd("rstmid_status", A_STAT, 8'h00);
    rd("rstmid_irqen", A_IEN, 8'h00);
    rd("rstmid_count", A_C1, 8'h00);

    cyc(); cyc();
    if (exp_q.size() != 0)
      $display("FAIL scoreboard_leftover: %0d expectations unconsumed, expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_total + exp_q.size());
    $finish;
  end

endmodule

// File: doc/gb_timer_multi.md
Name: gb_timer_multi

Overview:
- Parametrised multi-channel successor to the single DMG/CGB timer.
- Contains one shared free-running divider and CHANNELS independent reloadable counters.
- Each counter has a selectable prescale tap, a one-shot or auto-reload mode, and an optional chain from the previous channel's overflow.
- Sits on the CPU I/O bus beside the interrupt controller and raises one combined, maskable IRQ with cycle-exact delayed overflow semantics.

Parameters:
- CHANNELS, 2: number of counter channels, 1..7.
- CNT_W, 8: width of counter, reload and CPU data bus, 8..16.
- DIV_W, 16: divider width; must be >= CNT_W+8.
- IRQ_DELAY, 4: ce ticks from wrap to IRQ flag set, 1..8.
- TAP0, 9 / TAP1, 3 / TAP2, 5 / TAP3, 7: divider bit index selected by CTRL.sel = 0..3.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ce  in  1  timer clock enable (one M-cycle-aligned tick)
- cpu_sel  in  1  register select
- cpu_addr  in  AW=$clog2(CHANNELS+1)+2  address: {slot, reg[1:0]}
- cpu_wr  in  1  write strobe
- cpu_di  in  CNT_W  write data
- cpu_do  out  CNT_W  read data (combinational)
- irq  out  1  OR of (status & irq_en)
- ovf  out  CHANNELS  one-ce pulse per channel at wrap

Behaviour:
- Register map, slot 0 (global):
  - reg0 DIV = div[DIV_W-1 -: CNT_W]; any write clears the divider to 0.
  - reg1 STATUS; write-1-clear.
  - reg2 IRQ_EN.
  - reg3 and unmapped addresses read all ones.
- Register map, slot k (1..CHANNELS):
  - reg0 COUNT.
  - reg1 RELOAD.
  - reg2 CTRL = {..., chain[4], oneshot[3], en[2], sel[1:0]}; unused read bits = 1.
  - reg3 reads all ones.
- Reset values: divider, COUNT, RELOAD, CTRL, STATUS, IRQ_EN, delay pipes and edge registers all 0; irq=0; ovf=0. Reset mid-overflow discards the pending IRQ.
- Divider increments by 1 on every ce.
- Non-chained tick source t = en & div[TAPsel], sampled each ce. A tick occurs when t_prev=1 and t=0. A DIV write, CTRL write or en clear can therefore produce a spurious tick, matching hardware.
- Chained tick (chain=1, k>1): the tick is ovf[k-2] of the same ce, gated by en. Chain on channel 1 is ignored.
- On a tick, COUNT increments. A carry out of CNT_W wraps COUNT to 0, pulses ovf and starts a delay shift register.
- Delay pipe:
  - When the pipe reaches IRQ_DELAY, STATUS[k-1] is set.
  - On the following ce, COUNT := RELOAD.
  - If oneshot, en clears in that same ce.
- COUNT write during delay stages 1..IRQ_DELAY-1 cancels the pending IRQ and reload; the written value is taken.
- COUNT write in the flag-set ce is ignored; the reload still occurs.
- RELOAD write in the reload ce: the new cpu_di is loaded into COUNT directly.
- All register writes take effect on the next clk_sys edge only when ce=1, except the DIV clear and STATUS W1C, which are immediate.
- Same-cycle STATUS set and W1C of the same bit: set wins.
- irq is combinational from registered STATUS and IRQ_EN; no extra latency.
- Counter width arithmetic is modulo 2^CNT_W. Divider wraps modulo 2^DIV_W silently.

Decomposition:
- Package gb_timer_pkg holds:
  - register offset constants (REG_COUNT, REG_RELOAD, REG_CTRL, REG_DIV, REG_STATUS, REG_IRQEN);
  - CTRL bit-position constants;
  - the default tap table.
- One sub-module, gb_timer_channel, instantiated CHANNELS times via generate. It contains COUNT, RELOAD, CTRL, the edge detector, the delay pipe and the write-priority logic. Inputs are div, chain_in, ce and decoded write strobes; outputs are ovf, flag_set and read data.
- The top level owns the divider, STATUS/IRQ_EN, the address decode and the read mux.

Test Plan:
- CH1 CTRL=en,sel=1, RELOAD=0x80, COUNT=0xFE → wrap after 32 ce; STATUS[0] set exactly IRQ_DELAY ce after wrap; COUNT=0x80 one ce later; irq=1 only once IRQ_EN[0]=1.
- Wrap, then write COUNT=0x33 two ce later → no STATUS set, COUNT=0x33, no reload.
- RELOAD write of 0x55 in the reload ce → COUNT=0x55. COUNT write in the flag-set ce → ignored, COUNT=RELOAD.
- CH2 chain=1,en; CH1 RELOAD=0xFF, COUNT=0xFF, sel=1 → CH2 increments by 1 per CH1 wrap, i.e. every 16 ce; its ovf is aligned to CH1's ovf cycle.
- oneshot=1, COUNT=0xFF → a single IRQ, COUNT=RELOAD, en reads 0, no further ticks.
- DIV write while div[TAP] high with en=1 → exactly one spurious COUNT increment. Reset mid-delay → irq=0, STATUS=0 thereafter.
